// File: rtl/decision_run_sequencer_pkg.sv
// Shared definitions for the decision run sequencer.
//   state_e   : sequencer FSM state encoding
//   CLS_*     : one-hot class codes used by the classifier core and the LEDs
package decision_run_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RECORD = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  localparam logic [2:0] CLS_FILTER   = 3'b100;
  localparam logic [2:0] CLS_AIR      = 3'b010;
  localparam logic [2:0] CLS_ESPRESSO = 3'b001;
  localparam logic [2:0] CLS_NONE     = 3'b000;

endpackage

// File: rtl/decision_majority_vote.sv
// Majority vote over the three per-class tallies.
//   cnt_filter_i, cnt_air_i, cnt_espresso_i : class tallies
//   cls_o                                   : winning class code, CLS_NONE if all zero
// Ties resolve filter > air > espresso.
module decision_majority_vote
  import decision_run_sequencer_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic [CNT_W-1:0] cnt_filter_i,
  input  logic [CNT_W-1:0] cnt_air_i,
  input  logic [CNT_W-1:0] cnt_espresso_i,
  output logic [2:0]       cls_o
);

  always_comb begin
    cls_o = CLS_NONE;
    if ((cnt_filter_i == '0) && (cnt_air_i == '0) && (cnt_espresso_i == '0)) begin
      cls_o = CLS_NONE;
    end else if ((cnt_filter_i >= cnt_air_i) && (cnt_filter_i >= cnt_espresso_i)) begin
      cls_o = CLS_FILTER;
    end else if (cnt_air_i >= cnt_espresso_i) begin
      // filter has already lost to at least one of the other two here
      cls_o = CLS_AIR;
    end else begin
      cls_o = CLS_ESPRESSO;
    end
  end

endmodule

// File: rtl/decision_run_sequencer.sv
// Runs the classifier core over every stored sample, tallies the results and
// reports a majority class.
//   clk, rst                : clock, synchronous active-low reset
//   run_i, abort_i          : rising edge of run_i starts a run; abort_i cancels it
//   core_start_o/_index_o   : start pulse and sample index to the core
//   core_done_i/_class_i    : completion pulse and one-hot class from the core
//   busy_o, done_o          : run in progress / run-complete pulse (FINISH cycle)
//   led_o                   : majority class, valid the cycle after done_o
//   cnt_*_o, err_o          : per-class tallies, invalid/timeout flag for the run
//
// state  | meaning
// IDLE   | waiting for a run_i rising edge
// LAUNCH | core_start_o high for START_LEN cycles
// WAIT   | waiting for core_done_i, bounded by TIMEOUT cycles
// RECORD | tally the latched class, advance index
// FINISH | register majority class, pulse done_o
module decision_run_sequencer
  import decision_run_sequencer_pkg::*;
#(
  parameter int N_SAMPLES = 461,
  parameter int IDX_W     = 12,
  parameter int CNT_W     = 10,
  parameter int START_LEN = 3,
  parameter int TIMEOUT   = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             abort_i,
  output logic             core_start_o,
  output logic [IDX_W-1:0] core_index_o,
  input  logic             core_done_i,
  input  logic [2:0]       core_class_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       led_o,
  output logic [CNT_W-1:0] cnt_filter_o,
  output logic [CNT_W-1:0] cnt_air_o,
  output logic [CNT_W-1:0] cnt_espresso_o,
  output logic [CNT_W-1:0] cnt_invalid_o,
  output logic             err_o
);

  localparam int SL_W = $clog2(START_LEN + 1);
  localparam int TM_W = $clog2(TIMEOUT + 1);

  state_e           state_q;
  logic             run_prev_q;
  logic [IDX_W-1:0] idx_q;
  logic [SL_W-1:0]  start_cnt_q;
  logic [TM_W-1:0]  timer_q;
  logic [2:0]       cls_q;
  logic             core_start_q;
  logic             busy_q;
  logic             done_q;
  logic [2:0]       led_q;
  logic [CNT_W-1:0] cnt_filter_q;
  logic [CNT_W-1:0] cnt_air_q;
  logic [CNT_W-1:0] cnt_espresso_q;
  logic [CNT_W-1:0] cnt_invalid_q;
  logic             err_q;
  logic [2:0]       led_d;
  logic             run_rise;

  assign run_rise = run_i & ~run_prev_q;

  decision_majority_vote #(.CNT_W(CNT_W)) u_vote (
    .cnt_filter_i   (cnt_filter_q),
    .cnt_air_i      (cnt_air_q),
    .cnt_espresso_i (cnt_espresso_q),
    .cls_o          (led_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      run_prev_q     <= 1'b0;
      idx_q          <= '0;
      start_cnt_q    <= '0;
      timer_q        <= '0;
      cls_q          <= CLS_NONE;
      core_start_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      led_q          <= CLS_NONE;
      cnt_filter_q   <= '0;
      cnt_air_q      <= '0;
      cnt_espresso_q <= '0;
      cnt_invalid_q  <= '0;
      err_q          <= 1'b0;
    end else begin
      run_prev_q <= run_i;
      done_q     <= 1'b0;
      if (abort_i && (state_q != ST_IDLE)) begin
        // partial tallies and led_q are deliberately left intact
        state_q      <= ST_IDLE;
        core_start_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (run_rise) begin
              state_q        <= ST_LAUNCH;
              idx_q          <= '0;
              start_cnt_q    <= SL_W'(START_LEN - 1);
              core_start_q   <= 1'b1;
              busy_q         <= 1'b1;
              cnt_filter_q   <= '0;
              cnt_air_q      <= '0;
              cnt_espresso_q <= '0;
              cnt_invalid_q  <= '0;
              err_q          <= 1'b0;
            end
          end
          ST_LAUNCH: begin
            if (start_cnt_q == '0) begin
              state_q      <= ST_WAIT;
              core_start_q <= 1'b0;
              timer_q      <= TM_W'(TIMEOUT - 1);
            end else begin
              start_cnt_q <= start_cnt_q - SL_W'(1);
            end
          end
          ST_WAIT: begin
            // done is checked first so it wins over expiry in the same cycle
            if (core_done_i) begin
              cls_q   <= core_class_i;
              state_q <= ST_RECORD;
            end else if (timer_q == '0) begin
              cls_q   <= CLS_NONE;
              state_q <= ST_RECORD;
            end else begin
              timer_q <= timer_q - TM_W'(1);
            end
          end
          ST_RECORD: begin
            case (cls_q)
              CLS_FILTER:   if (cnt_filter_q != '1) cnt_filter_q <= cnt_filter_q + CNT_W'(1);
              CLS_AIR:      if (cnt_air_q != '1) cnt_air_q <= cnt_air_q + CNT_W'(1);
              CLS_ESPRESSO: if (cnt_espresso_q != '1) cnt_espresso_q <= cnt_espresso_q + CNT_W'(1);
              default: begin
                if (cnt_invalid_q != '1) cnt_invalid_q <= cnt_invalid_q + CNT_W'(1);
                err_q <= 1'b1;
              end
            endcase
            if (idx_q == IDX_W'(N_SAMPLES - 1)) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end else begin
              idx_q        <= idx_q + IDX_W'(1);
              state_q      <= ST_LAUNCH;
              start_cnt_q  <= SL_W'(START_LEN - 1);
              core_start_q <= 1'b1;
            end
          end
          ST_FINISH: begin
            // tallies are final only now, so led_o follows done_o by one cycle
            led_q   <= led_d;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q      <= ST_IDLE;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign core_start_o   = core_start_q;
  assign core_index_o   = idx_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign led_o          = led_q;
  assign cnt_filter_o   = cnt_filter_q;
  assign cnt_air_o      = cnt_air_q;
  assign cnt_espresso_o = cnt_espresso_q;
  assign cnt_invalid_o  = cnt_invalid_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_decision_run_sequencer.sv
module tb_decision_run_sequencer;

  localparam int IW = 12;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          run_i;
  logic          abort_i;
  logic          core_start_o;
  logic [IW-1:0] core_index_o;
  logic          core_done_i = 1'b0;
  logic [2:0]    core_class_i = 3'b000;
  logic          busy_o;
  logic          done_o;
  logic [2:0]    led_o;
  logic [CW-1:0] cnt_filter_o;
  logic [CW-1:0] cnt_air_o;
  logic [CW-1:0] cnt_espresso_o;
  logic [CW-1:0] cnt_invalid_o;
  logic          err_o;

  always #5 clk = ~clk;

  decision_run_sequencer #(
    .N_SAMPLES(4), .IDX_W(IW), .CNT_W(CW), .START_LEN(3), .TIMEOUT(20)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run_i          (run_i),
    .abort_i        (abort_i),
    .core_start_o   (core_start_o),
    .core_index_o   (core_index_o),
    .core_done_i    (core_done_i),
    .core_class_i   (core_class_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .led_o          (led_o),
    .cnt_filter_o   (cnt_filter_o),
    .cnt_air_o      (cnt_air_o),
    .cnt_espresso_o (cnt_espresso_o),
    .cnt_invalid_o  (cnt_invalid_o),
    .err_o          (err_o)
  );

  // Core model: done pulse dly_tab[idx] cycles after the first start cycle;
  // a delay of 0 means the core never answers for that index.
  logic [2:0] cls_tab [4];
  int         dly_tab [4];
  int         cd = 0;
  logic [2:0] pend = 3'b000;
  logic       start_prev = 1'b0;

  always @(negedge clk) begin
    core_done_i  = 1'b0;
    core_class_i = 3'b000;
    if (core_start_o && !start_prev && core_index_o < 4) begin
      cd   = dly_tab[core_index_o[1:0]];
      pend = cls_tab[core_index_o[1:0]];
    end else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        core_done_i  = 1'b1;
        core_class_i = pend;
      end
    end
    start_prev = core_start_o;
  end

  int checks = 0;
  int errors = 0;
  int start_hi [4];
  int done_cnt;
  int idx1_low;
  bit seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_tabs(input logic [2:0] c0, c1, c2, c3, input int d0, d1, d2, d3);
    cls_tab[0] = c0; cls_tab[1] = c1; cls_tab[2] = c2; cls_tab[3] = c3;
    dly_tab[0] = d0; dly_tab[1] = d1; dly_tab[2] = d2; dly_tab[3] = d3;
  endtask

  // Starts a run, monitors it at negedges, returns two cycles after done_o.
  task automatic run_once(input int repulse_at);
    int n;
    int post;
    for (int i = 0; i < 4; i++) start_hi[i] = 0;
    done_cnt = 0; idx1_low = 0; seen = 0; n = 0; post = 0;
    run_i = 1'b1;
    @(negedge clk);
    run_i = 1'b0;
    while (n < 2000 && post < 3) begin
      if (core_start_o && core_index_o < 4) start_hi[core_index_o[1:0]]++;
      if (busy_o && !core_start_o && core_index_o == 1) idx1_low++;
      if (done_o) begin done_cnt++; seen = 1'b1; end
      if (seen) post++;
      run_i = (n == repulse_at);
      @(negedge clk);
      n++;
    end
    run_i = 1'b0;
    chk("run_completes", 32'(seen), 1);
    chk("done_pulses", done_cnt, 1);
  endtask

  task automatic chk_counts(input string tag, input int f, a, e, inv, input logic er,
                            input logic [2:0] led);
    chk({tag, "_filter"}, 32'(cnt_filter_o), f);
    chk({tag, "_air"}, 32'(cnt_air_o), a);
    chk({tag, "_espresso"}, 32'(cnt_espresso_o), e);
    chk({tag, "_invalid"}, 32'(cnt_invalid_o), inv);
    chk({tag, "_err"}, 32'(err_o), 32'(er));
    chk({tag, "_led"}, 32'(led_o), 32'(led));
  endtask

  initial begin
    int n;
    set_tabs(3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
    rst = 1'b0; run_i = 1'b0; abort_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_start", 32'(core_start_o), 0);
    chk("rst_index", 32'(core_index_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk_counts("rst", 0, 0, 0, 0, 1'b0, 3'b000);
    rst = 1'b1;
    @(negedge clk);

    // nominal run, with a run_i re-edge while busy that must not restart
    set_tabs(3'b001, 3'b001, 3'b100, 3'b010, 5, 5, 5, 5);
    run_once(10);
    for (int i = 0; i < 4; i++) chk($sformatf("nom_start_len_idx%0d", i), start_hi[i], 3);
    chk("nom_idx1_latency", idx1_low, 4);
    chk_counts("nom", 1, 1, 2, 0, 1'b0, 3'b001);
    chk("nom_idle_after", 32'(busy_o), 0);

    // core silent on index 1: WAIT runs 20 cycles then RECORD
    set_tabs(3'b100, 3'b001, 3'b010, 3'b001, 5, 0, 5, 5);
    run_once(-1);
    chk("tmo_idx1_cycles", idx1_low, 21);
    chk("tmo_idx3_launched", start_hi[3], 3);
    chk_counts("tmo", 1, 1, 1, 1, 1'b1, 3'b100);

    // filter/air tie resolves to filter
    set_tabs(3'b100, 3'b010, 3'b100, 3'b010, 5, 5, 5, 5);
    run_once(-1);
    chk_counts("tie", 2, 2, 0, 0, 1'b0, 3'b100);

    // invalid code, and done arriving on the last WAIT cycle
    set_tabs(3'b011, 3'b010, 3'b001, 3'b010, 5, 22, 5, 5);
    run_once(-1);
    chk("sim_idx1_cycles", idx1_low, 21);
    chk_counts("sim", 0, 2, 1, 1, 1'b1, 3'b010);

    // abort in WAIT of index 2; the core's late done must be ignored
    set_tabs(3'b001, 3'b001, 3'b001, 3'b001, 5, 5, 5, 5);
    done_cnt = 0;
    run_i = 1'b1;
    @(negedge clk);
    run_i = 1'b0;
    n = 0;
    while (n < 200 && !(busy_o && !core_start_o && core_index_o == 2)) begin
      @(negedge clk);
      n++;
    end
    chk("abt_reached_wait", 32'(n < 200), 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abt_busy", 32'(busy_o), 0);
    chk("abt_start", 32'(core_start_o), 0);
    for (int i = 0; i < 12; i++) begin
      if (done_o) done_cnt++;
      @(negedge clk);
    end
    chk("abt_no_done", done_cnt, 0);
    chk("abt_still_idle", 32'(busy_o), 0);
    chk_counts("abt", 0, 0, 2, 0, 1'b0, 3'b010);

    // reset in the middle of a run
    set_tabs(3'b100, 3'b100, 3'b100, 3'b100, 5, 5, 5, 5);
    run_i = 1'b1;
    @(negedge clk);
    run_i = 1'b0;
    n = 0;
    while (n < 200 && !(core_start_o && core_index_o == 1)) begin
      @(negedge clk);
      n++;
    end
    chk("mrst_reached_idx1", 32'(n < 200), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_start_drop", 32'(core_start_o), 0);
    chk("mrst_busy_drop", 32'(busy_o), 0);
    @(negedge clk);
    rst = 1'b1;
    chk("mrst_index", 32'(core_index_o), 0);
    chk_counts("mrst", 0, 0, 0, 0, 1'b0, 3'b000);
    repeat (10) @(negedge clk);
    chk("mrst_stays_idle", 32'(busy_o), 0);
    chk("mrst_counts_hold", 32'(cnt_filter_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
